// File: rtl/press_classifier_pkg.sv
// press_classifier_pkg: state encoding, 50 MHz default tick counts and legality helper for press_classifier
package press_classifier_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRESSED, S_LONG_HELD, S_WAIT2, S_DRAIN} state_t;
  localparam int DEF_CNT_W        = 25;
  localparam int DEF_LONG_TICKS   = 25000000;
  localparam int DEF_REPEAT_TICKS = 5000000;
  localparam int DEF_DCLICK_TICKS = 12500000;
  function automatic logic ticks_ok(input int t, input int w);
    return (t >= 2) && (t < (1 << w));
  endfunction
endpackage

// File: rtl/press_timer.sv
// press_timer: interval up-counter with synchronous clear and equality compare against a selectable limit
module press_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_hit
);
  logic [CNT_W-1:0] r_cnt;
  // count in timed states; clear wins so every state entry starts from zero
  always_ff @(posedge clk)
    if (!rst_n || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CNT_W'(1);
  assign o_hit = (r_cnt == i_limit);
endmodule

// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into short/long/repeat (and optional double, macro PRESS_DCLICK_EN) press pulses
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic repeat_tick,
  output logic double_press,
  output logic busy
);
  if (!ticks_ok(LONG_TICKS, CNT_W) || !ticks_ok(REPEAT_TICKS, CNT_W) || !ticks_ok(DCLICK_TICKS, CNT_W)) begin : g_bad_ticks
    $error("press_classifier: each *_TICKS must be >= 2 and < 2**CNT_W");
  end
  state_t           r_state, w_next;
  logic             r_prev, r_short, r_long, r_rep;
  logic             w_rise, w_hit, w_clr, w_en, w_short, w_long, w_rep, w_dbl;
  logic [CNT_W-1:0] w_limit;
  assign w_rise  = btn_level & ~r_prev;
  assign w_en    = (r_state == S_PRESSED) || (r_state == S_LONG_HELD) || (r_state == S_WAIT2);
  assign w_limit = (r_state == S_LONG_HELD) ? CNT_W'(REPEAT_TICKS - 1) :
                   (r_state == S_WAIT2)     ? CNT_W'(DCLICK_TICKS - 1) : CNT_W'(LONG_TICKS - 1);
  assign w_clr   = (w_next != r_state) | w_rep;
  press_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_limit(w_limit),
    .o_hit  (w_hit)
  );
  // next state and the pulse to register at this edge
  always_comb begin
    w_next  = r_state;
    w_short = 1'b0;
    w_long  = 1'b0;
    w_rep   = 1'b0;
    w_dbl   = 1'b0;
    case (r_state)
      S_IDLE: w_next = w_rise ? S_PRESSED : S_IDLE;
      S_PRESSED:
        if (!btn_level) begin
`ifdef PRESS_DCLICK_EN
          w_next = S_WAIT2;
`else
          w_short = 1'b1;
          w_next  = S_IDLE;
`endif
        end else if (w_hit) begin
          w_long = 1'b1;
          w_next = S_LONG_HELD;
        end
      S_LONG_HELD:
        if (!btn_level) w_next = S_IDLE;
        else w_rep = w_hit;
`ifdef PRESS_DCLICK_EN
      S_WAIT2:
        if (w_hit) begin
          w_short = 1'b1;
          w_next  = w_rise ? S_PRESSED : S_IDLE;
        end else if (w_rise) begin
          w_dbl  = 1'b1;
          w_next = S_DRAIN;
        end
      S_DRAIN: w_next = btn_level ? S_DRAIN : S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  // state, previous level and registered pulses; previous level resets high so a held button is ignored
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prev  <= 1'b1;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prev  <= btn_level;
      r_short <= w_short;
      r_long  <= w_long;
      r_rep   <= w_rep;
    end
`ifdef PRESS_DCLICK_EN
  logic r_dbl;
  // double press pulse register
  always_ff @(posedge clk)
    if (!rst_n) r_dbl <= 1'b0;
    else r_dbl <= w_dbl;
  assign double_press = r_dbl;
`else
  assign double_press = 1'b0;
`endif
  assign short_press = r_short;
  assign long_press  = r_long;
  assign repeat_tick = r_rep;
  assign busy        = (r_state != S_IDLE);
endmodule
